mips_harvard_cpu: RTL and testbench

Single-cycle MIPS-I subset CPU with a Harvard interface: separate instruction and data buses.
- Instruction memory is read combinationally.
- Data memory has combinational read and write on the clock edge.
- The CPU starts at the MIPS reset vector and runs until it jumps to address 0, then drops `active`.
- The bench reports `register_v0` when the CPU halts.

---
 rtl/mips_pkg.sv | 38 +++
 rtl/mips_regfile.sv | 32 +++
 rtl/mips_harvard_cpu.sv | 183 ++++++++++++++++++
 tb/tb_mips_harvard_cpu.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS-I subset definitions: opcode/funct encodings, ALU operations, reset vector.
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_t;

endpackage

// File: rtl/mips_regfile.sv
// 32x32 general-purpose register file: two combinational read ports, one synchronous write port.
module mips_regfile
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        write_enable,
  input  logic [4:0]  read_addr1,
  input  logic [4:0]  read_addr2,
  input  logic [4:0]  write_addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2,
  output logic [31:0] v0
);

  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (write_enable && (write_addr != 5'd0)) begin
      regs[write_addr] <= write_data;
    end
  end

  // $0 is forced to zero on read so it never depends on storage contents
  assign read_data1 = (read_addr1 == 5'd0) ? 32'd0 : regs[read_addr1];
  assign read_data2 = (read_addr2 == 5'd0) ? 32'd0 : regs[read_addr2];
  assign v0         = regs[2];

endmodule

// File: rtl/mips_harvard_cpu.sv
// Single-cycle MIPS-I subset CPU with separate instruction/data buses and a one-instruction
// branch delay slot; halts when control transfers to address 0.
module mips_harvard_cpu #(
  parameter logic [31:0] RESET_VECTOR = mips_pkg::RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata,
  output logic [31:0] register_debug,
  output logic [31:0] alu1,
  output logic [31:0] alu2,
  output logic [31:0] instr_scheduler,
  output logic [31:0] reg32
);
  import mips_pkg::*;

  function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLT:  r = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'd0, a < b};
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
      ALU_LUI:  r = {b[15:0], 16'd0};
      default:  r = 32'd0;
    endcase
    return r;
  endfunction

  logic [31:0] pc, pc_plus4, pc_plus8, next_pc;
  logic [31:0] pending_target;
  logic        pending_valid, halted, run;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] sext_imm, zext_imm, branch_target, jump_target;
  logic [31:0] rs_val, rt_val, alu_result, write_data;

  alu_op_t     alu_op;
  logic [31:0] op_a, op_b, redirect_target;
  logic [4:0]  write_addr;
  logic        reg_write, is_load, is_store, is_link, redirect;

  assign opcode   = instr_readdata[31:26];
  assign rs       = instr_readdata[25:21];
  assign rt       = instr_readdata[20:16];
  assign rd       = instr_readdata[15:11];
  assign shamt    = instr_readdata[10:6];
  assign funct    = instr_readdata[5:0];
  assign sext_imm = {{16{instr_readdata[15]}}, instr_readdata[15:0]};
  assign zext_imm = {16'd0, instr_readdata[15:0]};

  assign pc_plus4      = pc + 32'd4;
  assign pc_plus8      = pc + 32'd8;
  assign branch_target = pc_plus4 + {sext_imm[29:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], instr_readdata[25:0], 2'b00};

  always_comb begin
    alu_op          = ALU_ADD;
    op_a            = rs_val;
    op_b            = rt_val;
    write_addr      = rd;
    reg_write       = 1'b0;
    is_load         = 1'b0;
    is_store        = 1'b0;
    is_link         = 1'b0;
    redirect        = 1'b0;
    redirect_target = branch_target;
    case (opcode)
      OP_SPECIAL: begin
        reg_write = 1'b1;
        case (funct)
          FN_ADDU: alu_op = ALU_ADD;
          FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLTU: alu_op = ALU_SLTU;
          FN_SLL, FN_SRL, FN_SRA: begin
            alu_op = (funct == FN_SLL) ? ALU_SLL : (funct == FN_SRL) ? ALU_SRL : ALU_SRA;
            op_a   = rt_val;
            op_b   = {27'd0, shamt};
          end
          FN_JR: begin
            reg_write       = 1'b0;
            redirect        = 1'b1;
            redirect_target = rs_val;
          end
          default: reg_write = 1'b0;
        endcase
      end
      OP_J, OP_JAL: begin
        redirect        = 1'b1;
        redirect_target = jump_target;
        reg_write       = (opcode == OP_JAL);
        is_link         = 1'b1;
        write_addr      = 5'd31;
      end
      OP_BEQ: redirect = (rs_val == rt_val);
      OP_BNE: redirect = (rs_val != rt_val);
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW: begin
        op_b       = sext_imm;
        write_addr = rt;
        alu_op     = (opcode == OP_SLTI) ? ALU_SLT : (opcode == OP_SLTIU) ? ALU_SLTU : ALU_ADD;
        is_load    = (opcode == OP_LW);
        is_store   = (opcode == OP_SW);
        reg_write  = (opcode != OP_SW);
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        op_b       = zext_imm;
        write_addr = rt;
        reg_write  = 1'b1;
        alu_op     = (opcode == OP_ANDI) ? ALU_AND : (opcode == OP_ORI) ? ALU_OR :
                     (opcode == OP_XORI) ? ALU_XOR : ALU_LUI;
      end
      default: ;
    endcase
  end

  assign alu_result = alu(alu_op, op_a, op_b);
  assign write_data = is_load ? data_readdata : (is_link ? pc_plus8 : alu_result);

  // Architectural state only advances on enabled cycles before halt
  assign run     = clk_enable && !halted;
  assign next_pc = pending_valid ? pending_target : pc_plus4;

  mips_regfile u_regfile (
    .clk          (clk),
    .reset        (reset),
    .write_enable (reg_write && run),
    .read_addr1   (rs),
    .read_addr2   (rt),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .read_data1   (rs_val),
    .read_data2   (rt_val),
    .v0           (register_v0)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc             <= RESET_VECTOR;
      pending_valid  <= 1'b0;
      pending_target <= 32'd0;
      halted         <= 1'b0;
    end else if (run) begin
      // Landing on address 0 halts instead of fetching; PC stays on the last executed word
      if (next_pc == 32'd0) halted <= 1'b1;
      else                  pc     <= next_pc;
      pending_valid  <= redirect;
      pending_target <= redirect_target;
    end
  end

  assign active          = !halted;
  assign instr_address   = pc;
  assign instr_scheduler = instr_readdata;
  assign data_address    = alu_result;
  assign data_writedata  = rt_val;
  assign data_write      = is_store && run;
  assign data_read       = is_load && run;
  assign register_debug  = rs_val;
  assign reg32           = rt_val;
  assign alu1            = op_a;
  assign alu2            = op_b;

endmodule

// File: tb/tb_mips_harvard_cpu.sv
// Directed and randomized program tests for mips_harvard_cpu against an instruction-level model.
module tb_mips_harvard_cpu;

  localparam logic [31:0] RV  = 32'hBFC0_0000;
  localparam logic [31:0] NOP = 32'd0;

  logic        clk, reset, clk_enable, active, data_write, data_read;
  logic [31:0] register_v0, instr_address, instr_readdata, data_address, data_writedata;
  logic [31:0] data_readdata, register_debug, alu1, alu2, instr_scheduler, reg32;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] imem [64];
  logic [31:0] dmem [16];

  mips_harvard_cpu dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .active(active),
    .register_v0(register_v0), .instr_address(instr_address), .instr_readdata(instr_readdata),
    .data_address(data_address), .data_write(data_write), .data_read(data_read),
    .data_writedata(data_writedata), .data_readdata(data_readdata),
    .register_debug(register_debug), .alu1(alu1), .alu2(alu2),
    .instr_scheduler(instr_scheduler), .reg32(reg32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    logic [31:0] off;
    off = instr_address - RV;
    instr_readdata = (off < 32'd256) ? imem[off[7:2]] : NOP;
  end

  assign data_readdata = dmem[data_address[5:2]];
  always @(posedge clk) if (data_write) dmem[data_address[5:2]] <= data_writedata;

  function automatic logic [31:0] enc_r(int fn, int rs, int rt, int rd, int sh);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
  endfunction
  function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) imem[i] = NOP;
    for (int i = 0; i < 16; i++) dmem[i] = 32'd0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clk_enable = 1'b1;
    step();
    reset = 1'b1;
  endtask

  task automatic run_to_halt(input int max_cycles, input string tag);
    int n;
    n = 0;
    while (active && n < max_cycles) begin
      step();
      n++;
    end
    chk(tag, {31'd0, active}, 32'd0);
  endtask

  // Instruction-level reference model: architectural state plus delay-slot bookkeeping
  logic [31:0] m_regs [32];
  logic [31:0] m_pc, m_tgt;
  logic        m_pend, m_halted;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pc = RV; m_pend = 1'b0; m_tgt = 32'd0; m_halted = 1'b0;
  endtask

  task automatic model_exec(input logic [31:0] w);
    int op, rs, rt, rd, sh, fn;
    logic [31:0] a, b, si, zi, res, nxt;
    logic wr, jump;
    int dst;
    op = int'(w[31:26]); rs = int'(w[25:21]); rt = int'(w[20:16]);
    rd = int'(w[15:11]); sh = int'(w[10:6]); fn = int'(w[5:0]);
    a = m_regs[rs]; b = m_regs[rt];
    si = {{16{w[15]}}, w[15:0]}; zi = {16'd0, w[15:0]};
    wr = 1'b1; jump = 1'b0; dst = rt; res = 32'd0;
    if (op == 0) begin
      dst = rd;
      case (fn)
        'h21: res = a + b;
        'h23: res = a - b;
        'h24: res = a & b;
        'h25: res = a | b;
        'h26: res = a ^ b;
        'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        'h2B: res = (a < b) ? 32'd1 : 32'd0;
        'h00: res = b << sh;
        'h02: res = b >> sh;
        'h03: res = $unsigned($signed(b) >>> sh);
        'h08: begin wr = 1'b0; jump = 1'b1; end
        default: wr = 1'b0;
      endcase
    end else begin
      case (op)
        'h09: res = a + si;
        'h0A: res = ($signed(a) < $signed(si)) ? 32'd1 : 32'd0;
        'h0B: res = (a < si) ? 32'd1 : 32'd0;
        'h0C: res = a & zi;
        'h0D: res = a | zi;
        'h0E: res = a ^ zi;
        'h0F: res = zi * 65536;
        default: wr = 1'b0;
      endcase
    end
    if (wr && dst != 0) m_regs[dst] = res;
    nxt = m_pend ? m_tgt : m_pc + 32'd4;
    m_pend = jump;
    m_tgt = a;
    if (nxt == 32'd0) m_halted = 1'b1;
    else m_pc = nxt;
  endtask

  function automatic logic [31:0] rand_instr();
    int k, d, s, t;
    d = ($urandom_range(0, 2) == 0) ? 2 : int'($urandom_range(1, 7));
    s = int'($urandom_range(0, 7));
    t = int'($urandom_range(0, 7));
    k = int'($urandom_range(0, 16));
    case (k)
      0: return enc_r('h21, s, t, d, 0);
      1: return enc_r('h23, s, t, d, 0);
      2: return enc_r('h24, s, t, d, 0);
      3: return enc_r('h25, s, t, d, 0);
      4: return enc_r('h26, s, t, d, 0);
      5: return enc_r('h2A, s, t, d, 0);
      6: return enc_r('h2B, s, t, d, 0);
      7: return enc_r('h00, 0, t, d, int'($urandom_range(0, 31)));
      8: return enc_r('h02, 0, t, d, int'($urandom_range(0, 31)));
      9: return enc_r('h03, 0, t, d, int'($urandom_range(0, 31)));
      10: return enc_i('h09, s, d, int'($urandom_range(0, 65535)));
      11: return enc_i('h0A, s, d, int'($urandom_range(0, 65535)));
      12: return enc_i('h0B, s, d, int'($urandom_range(0, 65535)));
      13: return enc_i('h0C, s, d, int'($urandom_range(0, 65535)));
      14: return enc_i('h0D, s, d, int'($urandom_range(0, 65535)));
      15: return enc_i('h0E, s, d, int'($urandom_range(0, 65535)));
      default: return enc_i('h0F, 0, d, int'($urandom_range(0, 65535)));
    endcase
  endfunction

  logic [31:0] hold_pc, hold_v0;

  initial begin
    reset = 1'b0;
    clk_enable = 1'b0;
    clear_mem();

    // Reset state
    do_reset();
    chk("reset_pc", instr_address, RV);
    chk("reset_active", {31'd0, active}, 32'd1);
    chk("reset_v0", register_v0, 32'd0);

    // ADDIU then jump to 0
    clear_mem();
    imem[0] = enc_i('h09, 0, 2, 5);
    imem[1] = enc_r('h08, 0, 0, 0, 0);
    do_reset();
    run_to_halt(4, "halt_simple");
    chk("v0_simple", register_v0, 32'd5);
    step();
    chk("pc_frozen", instr_address, RV + 32'd8);

    // Store/load round trip
    clear_mem();
    imem[0] = enc_i('h0F, 0, 3, 'h1234);
    imem[1] = enc_i('h0D, 3, 3, 'h5678);
    imem[2] = enc_i('h2B, 0, 3, 0);
    imem[3] = enc_i('h23, 0, 2, 0);
    imem[4] = enc_r('h08, 0, 0, 0, 0);
    do_reset();
    step(); step();
    chk("sw_write", {31'd0, data_write}, 32'd1);
    chk("sw_read", {31'd0, data_read}, 32'd0);
    chk("sw_addr", data_address, 32'd0);
    chk("sw_data", data_writedata, 32'h1234_5678);
    step();
    chk("lw_read", {31'd0, data_read}, 32'd1);
    chk("lw_write", {31'd0, data_write}, 32'd0);
    run_to_halt(10, "halt_mem");
    chk("v0_mem", register_v0, 32'h1234_5678);

    // Delay slot, unstalled then with a 3-cycle stall
    for (int pass = 0; pass < 2; pass++) begin
      clear_mem();
      imem[0] = enc_i('h09, 0, 2, 1);
      imem[1] = enc_i('h04, 0, 0, 2);
      imem[2] = enc_i('h09, 2, 2, 1);
      imem[3] = enc_i('h09, 2, 2, 100);
      imem[4] = enc_i('h09, 2, 2, 10);
      imem[5] = enc_r('h08, 0, 0, 0, 0);
      do_reset();
      if (pass == 1) begin
        step(); step();
        hold_pc = instr_address;
        hold_v0 = register_v0;
        chk("pre_stall_pc", hold_pc, RV + 32'd8);
        clk_enable = 1'b0;
        for (int s = 0; s < 3; s++) begin
          step();
          chk("stall_pc", instr_address, hold_pc);
          chk("stall_v0", register_v0, hold_v0);
          chk("stall_nowrite", {31'd0, data_write}, 32'd0);
        end
        clk_enable = 1'b1;
      end
      run_to_halt(20, "halt_branch");
      chk("v0_branch", register_v0, 32'd12);
    end

    // JAL / JR $31 round trip
    clear_mem();
    imem[0] = {6'h03, 26'h3F0_0008};
    imem[2] = enc_i('h09, 0, 2, 7);
    imem[3] = enc_r('h08, 0, 0, 0, 0);
    imem[8] = enc_r('h08, 31, 0, 0, 0);
    do_reset();
    step(); step();
    chk("jal_target", instr_address, RV + 32'h20);
    chk("jal_link", register_debug, RV + 32'd8);
    run_to_halt(20, "halt_jal");
    chk("v0_jal", register_v0, 32'd7);

    // Random ALU programs with random stalls against the model
    for (int prog = 0; prog < 4; prog++) begin
      int budget;
      clear_mem();
      for (int i = 0; i < 24; i++) imem[i] = rand_instr();
      imem[24] = enc_r('h08, 0, 0, 0, 0);
      do_reset();
      model_reset();
      budget = 0;
      while (!m_halted && budget < 200) begin
        if ($urandom_range(0, 3) == 0) begin
          clk_enable = 1'b0;
        end else begin
          clk_enable = 1'b1;
          model_exec(imem[(m_pc - RV) >> 2]);
        end
        step();
        chk("rand_pc", instr_address, m_pc);
        chk("rand_v0", register_v0, m_regs[2]);
        budget++;
      end
      clk_enable = 1'b1;
      chk("rand_halted", {31'd0, active}, 32'd0);
      chk("rand_model_done", {31'd0, m_halted}, 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
